fifo_wr_gen: RTL
================

// Module: fifo_wr_gen
// PURPOSE
//  Parametrised write-side traffic generator for FIFO IP bring-up on Kintex-7.
//  Arms on a synchronised FIFO empty flag, then streams a wrapping count (or LFSR)
//  pattern until almost_full or a programmed burst length is hit, then re-arms.
//  Sits between test control logic and the FIFO write port; reports word count,
//  burst completion and overflow for on-board checking.
// PARAMETERS
//  DATA_W      8     width of fifo_wr_data and of the pattern generator
//  WRAP_VAL    254   last count value before wrapping to 0; must be < 2**DATA_W
//  SYNC_STAGES 2     flop stages on the empty input; legal range 1..4
//  BURST_LEN   0     writes per burst; 0 = unbounded, stop only on almost_full
//  CNT_W       32    width of word_cnt
//  LFSR_TAPS   8'hB8 Galois feedback mask, used only with the LFSR feature
// PORTS
//  wr_clk        in   1       write clock; the only clock
//  rst           in   1       synchronous, active-high reset
//  enable        in   1       level; 1 = run the arm/write loop
//  wr_rst_busy   in   1       FIFO write-side reset in progress
//  empty         in   1       FIFO empty flag, may come from the other clock domain
//  almost_full   in   1       FIFO almost_full flag
//  full          in   1       FIFO full flag, monitored only
//  fifo_wr_en    out  1       registered write enable
//  fifo_wr_data  out  DATA_W  registered write data, valid when fifo_wr_en=1
//  busy          out  1       1 while state != IDLE
//  burst_done    out  1       one-cycle pulse when a burst ends
//  word_cnt      out  CNT_W   total writes since reset; wraps modulo 2**CNT_W
//  overflow_err  out  1       sticky; set when fifo_wr_en=1 and full=1 at an edge
// BEHAVIOUR
//  - rst=1 at an edge: state=IDLE, all outputs 0, sync chain 0, pattern=0 (LFSR seed 1).
//  - Write event = rising edge with fifo_wr_en=1. fifo_wr_data advances only on write
//    events: counter next = (data==WRAP_VAL) ? 0 : data+1. Data holds between bursts.
//  - empty_s = empty delayed by SYNC_STAGES flops; arming uses empty_s only.
//  - FSM:
//    IDLE : en=0. Go to ARM when enable=1 and wr_rst_busy=0.
//    ARM  : en=0. Go to WRITE when empty_s=1; fifo_wr_en=1 from the next cycle.
//           burst counter cleared.
//    WRITE: en=1. On a write event with almost_full=1, or with burst count = BURST_LEN-1
//           (BURST_LEN>0), go to DONE; en=0 in the next cycle. Exactly BURST_LEN writes.
//           One write may land after almost_full rises; the FIFO threshold must give >=1 slot.
//    DONE : one cycle, burst_done=1, en=0; then ARM if enable=1, else IDLE.
//  - enable=0 in ARM or WRITE: go to IDLE at the next edge. en=0 from that cycle.
//    No burst_done pulse.
//  - wr_rst_busy=1 in any state: go to IDLE at the next edge. en=0. Priority over
//    almost_full and burst end.
//  - Simultaneous almost_full and burst end: a single DONE entry and a single burst_done.
//  - word_cnt += 1 on each write event. overflow_err is cleared only by rst.
//  - full is never used to gate en; overflow_err flags bad threshold setup.
// CONFIGURATION
//  FIFO_WR_GEN_LFSR_EN defined: adds input pat_sel (1 bit).
//    pat_sel=1: on each write event, data next = (d>>1) ^ (d[0] ? LFSR_TAPS : 0). Seed 1.
//    pat_sel=0: counter pattern.
//    Changing pat_sel reloads the pattern register at the next ARM->WRITE: counter 0,
//    or LFSR seed 1.
//  Undefined: pat_sel port absent; counter pattern only; LFSR_TAPS ignored.
// TESTING
//  1 rst=1 for 3 cycles mid-burst -> all outputs 0, busy=0, word_cnt=0, data=0.
//  2 BURST_LEN=0, empty=1, almost_full rises after the 200th write -> data 0..199
//    (or 0..200), en drops next cycle, burst_done=1 for 1 cycle, busy stays 1 (ARM).
//  3 WRAP_VAL=254, 260 writes -> data ...253,254,0,1..4; word_cnt=260.
//  4 BURST_LEN=16 -> 16 writes (0..15), burst_done pulse; next empty_s -> burst 16..31.
//  5 wr_rst_busy=1 after 5 writes -> en=0 next cycle, state IDLE, data held at 5,
//    no burst_done.
//  6 full=1 while en=1 -> overflow_err=1, stays set after full=0 until rst.

Source files
------------

// File: rtl/fifo_wr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_gen
//  Purpose  : Write-side traffic generator for FIFO bring-up. Arms on a
//             synchronised empty flag, streams a wrapping count (or LFSR)
//             pattern until almost_full or the burst length is reached,
//             then re-arms. Reports word count, burst completion and
//             overflow (write attempted while full).
//  Options  : FIFO_WR_GEN_LFSR_EN - adds pat_sel input and LFSR pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_gen #(
    parameter int                DATA_W      = 8,
    parameter int                WRAP_VAL    = 254,
    parameter int                SYNC_STAGES = 2,
    parameter int                BURST_LEN   = 0,
    parameter int                CNT_W       = 32,
    parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(8'hB8)
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr_rst_busy,
    input  logic              empty,
    input  logic              almost_full,
    input  logic              full,
`ifdef FIFO_WR_GEN_LFSR_EN
    input  logic              pat_sel,
`endif
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              burst_done,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              overflow_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] c_WRAP = DATA_W'(WRAP_VAL);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_empty_sync;
    logic                    w_empty_s;
    logic [31:0]             r_burst_cnt;
    logic                    w_burst_end;
    logic                    w_wr_evt;
    logic                    r_wr_en;
    logic                    r_busy;
    logic                    r_burst_done;
    logic [CNT_W-1:0]        r_word_cnt;
    logic                    r_overflow;
    logic [DATA_W-1:0]       r_data;
    logic [DATA_W-1:0]       w_cnt_nxt;

    // A write happens on every edge where the registered enable is high
    assign w_wr_evt  = r_wr_en;
    assign w_empty_s = r_empty_sync[SYNC_STAGES-1];
    assign w_cnt_nxt = (r_data == c_WRAP) ? '0 : r_data + DATA_W'(1);

    // Empty flag synchroniser; the flag may originate in the read domain
    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            always_ff @(posedge wr_clk) begin
                if (rst) r_empty_sync <= '0;
                else     r_empty_sync <= empty;
            end
        end else begin : g_sync_multi
            always_ff @(posedge wr_clk) begin
                if (rst) r_empty_sync <= '0;
                else     r_empty_sync <= {r_empty_sync[SYNC_STAGES-2:0], empty};
            end
        end
    endgenerate

    // Burst-length terminal count; an unbounded burst never ends on count
    generate
        if (BURST_LEN > 0) begin : g_burst_bounded
            assign w_burst_end = (r_burst_cnt == 32'(BURST_LEN - 1));
        end else begin : g_burst_unbounded
            logic w_unused_bcnt;
            assign w_unused_bcnt = ^r_burst_cnt;
            assign w_burst_end   = 1'b0;
        end
    endgenerate

    // Next-state decode; FIFO reset and enable removal override burst end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && !wr_rst_busy) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (wr_rst_busy || !enable) w_state_nxt = S_IDLE;
                else if (w_empty_s)         w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (wr_rst_busy || !enable)          w_state_nxt = S_IDLE;
                else if (almost_full || w_burst_end) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (wr_rst_busy || !enable) w_state_nxt = S_IDLE;
                else                        w_state_nxt = S_ARM;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_burst_cnt  <= '0;
            r_word_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_en      <= (w_state_nxt == S_WRITE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_burst_done <= (w_state_nxt == S_DONE);
            if (r_state == S_ARM)
                r_burst_cnt <= '0;
            else if (w_wr_evt)
                r_burst_cnt <= r_burst_cnt + 32'd1;
            if (w_wr_evt)
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (w_wr_evt && full)
                r_overflow <= 1'b1;
        end
    end

`ifdef FIFO_WR_GEN_LFSR_EN
    logic              r_pat_mode;
    logic              w_reload;
    logic [DATA_W-1:0] w_lfsr_nxt;

    // Mode change takes effect only when a new burst starts
    assign w_reload   = (r_state == S_ARM) && (w_state_nxt == S_WRITE) &&
                        (pat_sel != r_pat_mode);
    assign w_lfsr_nxt = (r_data >> 1) ^ (r_data[0] ? LFSR_TAPS : '0);

    // Pattern register: reload on mode change, advance on each write
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_data     <= '0;
            r_pat_mode <= 1'b0;
        end else if (w_reload) begin
            r_data     <= pat_sel ? DATA_W'(1) : '0;
            r_pat_mode <= pat_sel;
        end else if (w_wr_evt) begin
            r_data <= r_pat_mode ? w_lfsr_nxt : w_cnt_nxt;
        end
    end
`else
    logic w_unused_taps;
    assign w_unused_taps = ^LFSR_TAPS;

    // Pattern register: wrapping counter advanced on each write
    always_ff @(posedge wr_clk) begin
        if (rst)           r_data <= '0;
        else if (w_wr_evt) r_data <= w_cnt_nxt;
    end
`endif

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_data;
    assign busy         = r_busy;
    assign burst_done   = r_burst_done;
    assign word_cnt     = r_word_cnt;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire
